xs3_to_bcd_seq: RTL
===================

# xs3_to_bcd_seq

Multi-digit Excess-3 to packed-BCD decoder. It accepts one DIGITS-wide Excess-3 word over a valid/ready handshake and decodes it one digit per clock, least-significant digit first. It flags every nibble outside the legal Excess-3 range and presents the BCD result on a second valid/ready handshake. It sits on the return path of the BCD→Excess-3 encoding, so packed-BCD consumers (display drivers, decimal arithmetic) can take Excess-3 traffic.

## Interface
Parameters:
- DIGITS, 4, number of 4-bit digits per word; legal range 1..16.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  in_xs3 holds a word.
- in_ready  out  1  block can accept a word; high only in IDLE.
- in_xs3  in  4*DIGITS  Excess-3 word; digit k is in bits [4k+3:4k].
- out_valid  out  1  out_bcd, out_err and out_err_mask hold a result.
- out_ready  in  1  downstream accepts the result.
- out_bcd  out  4*DIGITS  packed BCD result, same digit ordering as in_xs3.
- out_err  out  1  OR of out_err_mask.
- out_err_mask  out  DIGITS  bit k is set when input digit k was illegal.

## Operation
- FSM states: IDLE, CONV, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture in_xs3 into the word register, set digit index idx=0, clear out_bcd and out_err_mask, go to CONV.
- CONV:
  - Each cycle decode digit idx of the captured word and write it to out_bcd[4*idx+:4] and out_err_mask[idx].
  - When idx==DIGITS-1, go to DONE; otherwise idx+1.
- Digit decode for a nibble x:
  - If 3 ≤ x ≤ 12: bcd = x−3 (4-bit subtract, no carry out), error bit 0.
  - Otherwise (0,1,2,13,14,15): bcd = 4'hF, error bit 1.
- DONE:
  - out_valid=1; outputs are held stable.
  - On out_ready, go to IDLE.
- in_valid is ignored outside IDLE. in_xs3 may change after acceptance without effect.
- out_ready is ignored outside DONE.
- The index register is ceil(log2(DIGITS)) bits wide, minimum 1; it never wraps past DIGITS-1.

## Timing
- Reset (rst_n low, asynchronous):
  - state=IDLE, idx=0.
  - out_bcd=0, out_err_mask=0, out_err=0, out_valid=0.
  - in_ready=1, decoded from state, so it reads 1 while reset is asserted.
- Acceptance at edge T puts the FSM in CONV during cycles T+1..T+DIGITS.
- out_valid rises after edge T+DIGITS; latency is DIGITS cycles.
- An output handshake at edge U returns the FSM to IDLE; in_ready=1 in cycle U+1.
- Minimum issue interval is DIGITS+2 cycles. Input and output never overlap.
- DIGITS=1: one CONV cycle, then DONE.
- Reset mid-CONV or mid-DONE: the word is discarded, all outputs take their reset values immediately, and no out_valid pulse is produced for the aborted word.
- in_valid and out_ready are sampled only at rising edges. No combinational path exists from in_valid to in_ready or from out_ready to out_valid.

## Structure
- Package xs3_pkg holds:
  - state enum (IDLE, CONV, DONE);
  - constants XS3_MIN=4'd3, XS3_MAX=4'd12, XS3_OFFSET=4'd3, BCD_ERR_NIBBLE=4'hF.
- Sub-module xs3_digit_dec (combinational): input 4-bit nibble; outputs 4-bit bcd and 1-bit err. Instantiated once and fed from a mux selecting digit idx.

## Test plan
All scenarios run with DIGITS=4.
- Legal word: in_xs3=16'h4567 accepted at edge T → out_valid rises after edge T+4, out_bcd=16'h1234, out_err_mask=4'b0000, out_err=0.
- Range boundaries:
  - 16'h3333 → out_bcd=16'h0000, no error.
  - 16'hCCCC → out_bcd=16'h9999, no error.
- Illegal digits: 16'h2D45 → out_bcd=16'hFF12, out_err_mask=4'b1100, out_err=1. Then 16'hF0E1 → out_bcd=16'hFFFF, out_err_mask=4'b1111.
- Backpressure: out_ready held low for 5 cycles after out_valid rises → outputs stable, in_ready=0, and an in_valid pulse with 16'h5555 is ignored. Then out_ready=1 → in_ready=1 in the next cycle, and 16'h5555 accepted afterwards yields 16'h2222.
- Reset mid-conversion: rst_n low 2 cycles after accepting 16'h9999 → out_valid=0, out_bcd=0, in_ready=1 immediately. After release, 16'h4444 yields 16'h1111 with no stale digits.
- Back-to-back with continuous out_ready=1: 16'h3456 then 16'hC9A8 → results 16'h0123 then 16'h9675, issue interval 6 cycles.

Source files
------------

// File: rtl/xs3_pkg.sv
`default_nettype none
// ============================================================================
// Module      : xs3_pkg
// Description : Shared types and constants for the Excess-3 to packed-BCD
//               decoder: controller state encoding, legal Excess-3 range,
//               offset and the nibble reported for illegal digits.
// Revision    : 1.0 - initial release
// ============================================================================
package xs3_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } xs3_state_t;

    localparam logic [3:0] XS3_MIN        = 4'd3;
    localparam logic [3:0] XS3_MAX        = 4'd12;
    localparam logic [3:0] XS3_OFFSET     = 4'd3;
    localparam logic [3:0] BCD_ERR_NIBBLE = 4'hF;

endpackage : xs3_pkg
`default_nettype wire

// File: rtl/xs3_digit_dec.sv
`default_nettype none
// ============================================================================
// Module      : xs3_digit_dec
// Description : Combinational single-digit Excess-3 to BCD decoder.
//               Ports: nibble (in, 4)  Excess-3 digit
//                      bcd    (out, 4) decoded digit, 4'hF when illegal
//                      err    (out, 1) digit outside 3..12
// Revision    : 1.0 - initial release
// ============================================================================
module xs3_digit_dec
    import xs3_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [3:0] bcd,
    output logic       err
);

    logic w_illegal;

    assign w_illegal = (nibble < XS3_MIN) || (nibble > XS3_MAX);
    assign err       = w_illegal;
    // Subtraction is modulo 16; it only matters for legal digits, where it
    // never borrows.
    assign bcd       = w_illegal ? BCD_ERR_NIBBLE : (nibble - XS3_OFFSET);

endmodule : xs3_digit_dec
`default_nettype wire

// File: rtl/xs3_to_bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : xs3_to_bcd_seq
// Description : Multi-digit Excess-3 to packed-BCD decoder. Accepts one word
//               over a valid/ready handshake, decodes one digit per clock
//               (least-significant first) and presents the result on a
//               second valid/ready handshake.
//               Ports: clk, rst_n (async, active-low)
//                      in_valid/in_ready/in_xs3[4*DIGITS]    input word
//                      out_valid/out_ready/out_bcd[4*DIGITS] result
//                      out_err, out_err_mask[DIGITS]         illegal digits
// Revision    : 1.0 - initial release
// ============================================================================
module xs3_to_bcd_seq
    import xs3_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   in_xs3,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic                  out_err,
    output logic [DIGITS-1:0]     out_err_mask
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] c_idx_last = IDX_W'(DIGITS - 1);

    xs3_state_t             r_state;
    xs3_state_t             w_state_nxt;
    logic [4*DIGITS-1:0]    r_word;
    logic [IDX_W-1:0]       r_idx;
    logic [4*DIGITS-1:0]    r_bcd;
    logic [DIGITS-1:0]      r_mask;

    logic [3:0]             w_digits [DIGITS];
    logic [3:0]             w_nibble;
    logic [3:0]             w_bcd;
    logic                   w_err;

    // Split the captured word into digits so the decoder is fed by a
    // single array select on the digit index.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_split
            assign w_digits[gi] = r_word[4*gi +: 4];
        end
    endgenerate

    assign w_nibble = w_digits[r_idx];

    xs3_digit_dec u_dec (
        .nibble (w_nibble),
        .bcd    (w_bcd),
        .err    (w_err)
    );

    // ------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid)             w_state_nxt = CONV;
            CONV:    if (r_idx == c_idx_last)  w_state_nxt = DONE;
            DONE:    if (out_ready)            w_state_nxt = IDLE;
            default:                           w_state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word <= '0;
            r_idx  <= '0;
            r_bcd  <= '0;
            r_mask <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_word <= in_xs3;
                        r_idx  <= '0;
                        r_bcd  <= '0;
                        r_mask <= '0;
                    end
                end
                CONV: begin
                    r_bcd[4*r_idx +: 4] <= w_bcd;
                    r_mask[r_idx]       <= w_err;
                    // Index parks on the last digit instead of wrapping.
                    if (r_idx != c_idx_last) begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready     = (r_state == IDLE);
    assign out_valid    = (r_state == DONE);
    assign out_bcd      = r_bcd;
    assign out_err_mask = r_mask;
    assign out_err      = |r_mask;

endmodule : xs3_to_bcd_seq
`default_nettype wire
